fetch_unit: RTL and testbench

Parametrised instruction-fetch front end that replaces the fixed-step program counter and registered ROM lookup with a decoupled, queued fetch path. It holds the fetch PC, issues pipelined requests to an instruction memory over a valid/ready request channel, and tracks outstanding in-order responses. Fetched instructions are buffered with their PCs in a DEPTH-entry queue and presented to decode over a valid/ready channel. A redirect input, driven by branch/jump resolution, flushes the queue and restarts fetch.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Decoupled instruction-fetch front end. Holds the fetch PC, issues pipelined
//   word-aligned requests to instruction memory, tracks in-order responses, and
//   buffers fetched instructions with their PCs in a DEPTH-entry queue that
//   feeds decode. A redirect flushes the queue and restarts fetch. Responses
//   to requests that were in flight at a redirect are counted and discarded.
//
// Optional feature (macro FETCH_BYPASS_EN):
//   defined   - a response arriving while no filled entry is queued is shown on
//               out_* in the same cycle and, if consumed, is never stored.
//   undefined - every response is registered first; out_* comes from flops.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   imem_req_valid/ready  request handshake, imem_req_addr = fetch PC
//   imem_rsp_valid/data   in-order response, one per accepted request
//   redirect_valid/pc     flush queue and restart fetch at redirect_pc & ~3
//   out_valid/ready       decode handshake, out_instr / out_pc = queue head
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;  // extra wrap bit distinguishes full from empty

  typedef logic [PW-1:0] ptr_t;

  logic [XLEN-1:0]  r_fetch_pc;
  ptr_t             r_alloc, r_fill, r_head, r_drop_cnt;
  logic [XLEN-1:0]  r_pc_q    [DEPTH];
  logic [ILEN-1:0]  r_instr_q [DEPTH];
  logic [DEPTH-1:0] r_filled;

  logic [AW-1:0]    w_alloc_idx, w_fill_idx, w_head_idx;
  ptr_t             w_inflight;
  logic [PW:0]      w_credit_used;
  logic             w_drop_active, w_rsp_drop, w_rsp_write, w_rsp_take;
  logic             w_req_fire, w_pop, w_bypass, w_store;
  logic [XLEN-1:0]  w_redirect_pc;

  assign w_alloc_idx = r_alloc[AW-1:0];
  assign w_fill_idx  = r_fill[AW-1:0];
  assign w_head_idx  = r_head[AW-1:0];

  // Credit covers both live entries and responses still owed from before a
  // redirect, so a slot is always free when any response arrives.
  assign w_inflight    = r_alloc - r_head;
  assign w_credit_used = {1'b0, w_inflight} + {1'b0, r_drop_cnt};

  assign w_drop_active = (r_drop_cnt != '0);
  assign w_rsp_drop    = imem_rsp_valid & w_drop_active;
  // A response with nothing outstanding is ignored outright.
  assign w_rsp_write   = imem_rsp_valid & ~w_drop_active & (r_fill != r_alloc);
  assign w_rsp_take    = w_rsp_drop | w_rsp_write;

  assign w_redirect_pc = redirect_pc & ~XLEN'(3);

  assign imem_req_valid = reset & ~redirect_valid & (w_credit_used < (PW+1)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

`ifdef FETCH_BYPASS_EN
  // Entries fill in order from head, so fill == head means nothing is filled.
  assign w_bypass  = w_rsp_write & (r_fill == r_head);
  assign out_instr = w_bypass ? imem_rsp_data : r_instr_q[w_head_idx];
`else
  assign w_bypass  = 1'b0;
  assign out_instr = r_instr_q[w_head_idx];
`endif

  assign out_valid = ~redirect_valid & (r_filled[w_head_idx] | w_bypass);
  assign out_pc    = r_pc_q[w_head_idx];
  assign w_pop     = out_valid & out_ready;
  // A bypassed response taken by decode this cycle is never written.
  assign w_store   = w_rsp_write & ~(w_bypass & out_ready);

  // NOTE: the queue payload is reset too, so out_pc/out_instr read 0 during
  // reset instead of whatever the array held before.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_alloc    <= '0;
      r_fill     <= '0;
      r_head     <= '0;
      r_drop_cnt <= '0;
      r_filled   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_q[i]    <= '0;
        r_instr_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Every request between fill and alloc now owes a response to discard.
      r_fetch_pc <= w_redirect_pc;
      r_head     <= r_alloc;
      r_fill     <= r_alloc;
      r_filled   <= '0;
      r_drop_cnt <= r_drop_cnt + (r_alloc - r_fill) - ptr_t'(w_rsp_take);
    end else begin
      if (w_req_fire) begin
        r_pc_q[w_alloc_idx]   <= r_fetch_pc;
        r_filled[w_alloc_idx] <= 1'b0;
        r_alloc               <= r_alloc + 1'b1;
        r_fetch_pc            <= r_fetch_pc + XLEN'(4);
      end
      if (w_rsp_drop) begin
        r_drop_cnt <= r_drop_cnt - 1'b1;
      end
      if (w_rsp_write) begin
        r_fill <= r_fill + 1'b1;
      end
      if (w_store) begin
        r_instr_q[w_fill_idx] <= imem_rsp_data;
        r_filled[w_fill_idx]  <= 1'b1;
      end
      if (w_pop) begin
        r_filled[w_head_idx] <= 1'b0;
        r_head               <= r_head + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit (RESET_PC = 0xFFFFFFF8 so address wrap
//   is exercised from the first fetch). A behavioural memory returns addr+0x100
//   with a per-request latency; every accepted request pushes its expected
//   {pc, instr} onto a scoreboard queue that is popped at each decode handshake
//   and flushed at each redirect.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam int          ILEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_LAT = 1;
`else
  localparam int FIRST_LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            imem_req_valid, imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid, out_ready;
  logic [ILEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  fetch_unit #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mem_req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mem_req_t    mem_q[$];
  exp_t        exp_q[$];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, lat = 1;
  logic [31:0] m_pc;
  // per-phase observations
  int          ph_req, ph_out, ph_first_req_cyc, ph_first_out_cyc;
  logic [31:0] ph_first_req_addr, ph_first_out_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic new_phase();
    ph_req = 0; ph_out = 0; ph_first_req_cyc = -1; ph_first_out_cyc = -1;
    ph_first_req_addr = '0; ph_first_out_pc = '0;
  endtask

  task automatic drive_rsp();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].addr + 32'h100;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  // One clock cycle: observe handshakes at negedge, update models, advance.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (redirect_valid) begin
      check("redir_out_valid", 64'(out_valid), 64'd0);
      check("redir_req_valid", 64'(imem_req_valid), 64'd0);
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", 64'(imem_req_addr), 64'(m_pc));
      mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
      exp_q.push_back('{pc: imem_req_addr, instr: imem_req_addr + 32'h100});
      m_pc = m_pc + 32'd4;
      if (ph_req == 0) begin
        ph_first_req_cyc  = cyc;
        ph_first_req_addr = imem_req_addr;
      end
      ph_req++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected_pc", 64'(out_pc), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", 64'(out_pc), 64'(e.pc));
        check("out_instr", 64'(out_instr), 64'(e.instr));
      end
      if (ph_out == 0) begin
        ph_first_out_cyc = cyc;
        ph_first_out_pc  = out_pc;
      end
      ph_out++;
    end
    if (imem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
    if (redirect_valid) begin
      exp_q.delete();
      m_pc = redirect_pc & ~32'd3;
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_rsp();
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    reset = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    m_pc = RESET_PC;
    new_phase();

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);

    // 1: streaming with 1-cycle memory, wraps from 0xFFFFFFF8 through 0.
    @(posedge clk); #1;
    reset = 1'b1;
    lat = 1;
    repeat (20) step();
    check("t1_first_req", 64'(ph_first_req_addr), 64'(RESET_PC));
    check("t1_latency", 64'(ph_first_out_cyc - ph_first_req_cyc), 64'(FIRST_LAT));
    check("t1_throughput", 64'(ph_out >= 17), 64'd1);

    // 2: decode stalled -> exactly DEPTH requests, then drain in order.
    out_ready = 1'b0;
    redirect_to(32'h1000);
    new_phase();
    repeat (12) step();
    check("t2_req_count", 64'(ph_req), 64'(DEPTH));
    check("t2_req_blocked", 64'(imem_req_valid), 64'd0);
    check("t2_held_pc", 64'(out_pc), 64'h1000);
    new_phase();
    out_ready = 1'b1;
    repeat (10) step();
    check("t2_first_out", 64'(ph_first_out_pc), 64'h1000);
    check("t2_resume_addr", 64'(ph_first_req_addr), 64'h1010);

    // 3: 3-cycle memory, redirect with three requests in flight.
    lat = 3;
    redirect_to(32'h0500);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_q.size() == 3) found = 1;
      else step();
    end
    check("t3_three_outstanding", 64'(found), 64'd1);
    new_phase();
    redirect_to(32'h0203);
    repeat (12) step();
    check("t3_req_addr", 64'(ph_first_req_addr), 64'h200);
    check("t3_first_out", 64'(ph_first_out_pc), 64'h200);

    // 4: redirect coincident with a response and a decode handshake.
    lat = 1;
    redirect_to(32'h2000);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_rsp_valid && out_valid) found = 1;
      else step();
    end
    check("t4_found_overlap", 64'(found), 64'd1);
    new_phase();
    redirect_to(32'h3000);
    check("t4_no_pop", 64'(ph_out), 64'd0);
    check("t4_out_valid_after", 64'(out_valid), 64'd0);
    repeat (10) step();
    check("t4_first_out", 64'(ph_first_out_pc), 64'h3000);

    // 5: async reset with filled entries waiting.
    out_ready = 1'b0;
    redirect_to(32'h4000);
    repeat (4) step();
    check("t5_pre_valid", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_out_pc", 64'(out_pc), 64'd0);
    check("t5_out_instr", 64'(out_instr), 64'd0);
    check("t5_req_valid", 64'(imem_req_valid), 64'd0);
    check("t5_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
    mem_q.delete(); exp_q.delete();
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    m_pc = RESET_PC;
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    new_phase();
    repeat (8) step();
    check("t5_first_req", 64'(ph_first_req_addr), 64'(RESET_PC));
    check("t5_first_out", 64'(ph_first_out_pc), 64'(RESET_PC));

    // 6: random ready/latency/redirect mix against the scoreboard.
    new_phase();
    for (int i = 0; i < 400; i++) begin
      lat            = int'($urandom_range(1, 3));
      imem_req_ready = 1'($urandom_range(0, 3) != 0);
      out_ready      = 1'($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 29) == 0) begin
        redirect_to($urandom());
      end else begin
        step();
      end
    end
    check("t6_progress", 64'(ph_out > 50), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
